// File: rtl/seq_arb_pkg.sv
// Shared types and defaults for the time-multiplexed "1101" detector arbiter.
package seq_arb_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,  // idle
    S1 = 2'd1,  // seen "1"
    S2 = 2'd2,  // seen "11"
    S3 = 2'd3   // seen "110"
  } det_state_t;

  localparam int DEF_NCH   = 4;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/seq_det_step.sv
// One step of the "1101" Mealy detector: next context and hit for a single bit.
// Define SEQ_ARB_NONOVERLAP_EN to restart from idle after a hit (non-overlapping).
module seq_det_step
  import seq_arb_pkg::*;
(
  input  det_state_t state_i,
  input  logic       x_i,
  output det_state_t state_o,
  output logic       hit_o
);

  always_comb begin
    state_o = S0;
    hit_o   = 1'b0;
    case (state_i)
      S0: state_o = x_i ? S1 : S0;
      S1: state_o = x_i ? S2 : S0;
      S2: state_o = x_i ? S2 : S3;
      S3: begin
        hit_o = x_i;
`ifdef SEQ_ARB_NONOVERLAP_EN
        state_o = S0;
`else
        // The trailing "1" of a hit doubles as the leading "1" of the next match.
        state_o = x_i ? S1 : S0;
`endif
      end
      default: state_o = S0;
    endcase
  end

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter sharing one "1101" detector step across NCH serial channels.
// Optional build macro: SEQ_ARB_NONOVERLAP_EN (non-overlapping detection).
module seq_det_arbiter
  import seq_arb_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int CH_W  = $clog2(NCH),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   bit_in,
  input  logic [NCH-1:0]   clr,
  output logic [NCH-1:0]   gnt,
  output logic             det_valid,
  output logic [CH_W-1:0]  det_ch,
  output logic [CNT_W-1:0] hit_cnt
);

  // Handshake: a source holds req[i] with bit_in[i] until it sees gnt[i]; the bit is
  // consumed on the rising edge where req[i] & gnt[i]. clr[i] withholds the grant
  // for that cycle, so a pending request simply waits.

  det_state_t       ctx_q [NCH];
  det_state_t       ctx_d [NCH];
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             det_valid_q, det_valid_d;
  logic [CH_W-1:0]  det_ch_q, det_ch_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  logic [NCH-1:0]   eligible;
  logic [NCH-1:0]   gnt_c;
  logic             gnt_any;
  logic [CH_W-1:0]  gnt_idx;
  logic             hi_any, lo_any;
  logic [CH_W-1:0]  hi_idx, lo_idx;

  det_state_t       step_state;
  det_state_t       step_next;
  logic             step_hit;

  assign eligible = req & ~clr;

  // Lowest eligible index at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_any = 1'b1;
        lo_idx = CH_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_any = 1'b1;
          hi_idx = CH_W'(i);
        end
      end
    end
    gnt_any = lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

  assign step_state = ctx_q[gnt_idx];

  seq_det_step u_step (
    .state_i (step_state),
    .x_i     (bit_in[gnt_idx]),
    .state_o (step_next),
    .hit_o   (step_hit)
  );

  // Next-state logic for the context array, pointer and detection registers.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ctx_d[i] = clr[i] ? S0 : ctx_q[i];
    end
    if (gnt_any) begin
      ctx_d[gnt_idx] = step_next;
    end

    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end

    det_valid_d = gnt_any & step_hit;
    det_ch_d    = det_valid_d ? gnt_idx : det_ch_q;
    hit_cnt_d   = hit_cnt_q + CNT_W'(det_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= S0;
      end
      ptr_q       <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      hit_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= ctx_d[i];
      end
      ptr_q       <= ptr_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

  // Output logic; the grant is masked by reset so nothing is consumed while held.
  always_comb begin
    gnt_c = '0;
    if (gnt_any) begin
      gnt_c[gnt_idx] = 1'b1;
    end
    gnt       = rst_n ? gnt_c : '0;
    det_valid = det_valid_q;
    det_ch    = det_ch_q;
    hit_cnt   = hit_cnt_q;
  end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Scoreboard bench for seq_det_arbiter: directed scenarios plus random traffic
// checked against a bit-history reference model.
module tb_seq_det_arbiter;

  localparam int NCH   = 4;
  localparam int CH_W  = 2;
  localparam int CNT_W = 4;
  localparam int GW    = 32 + NCH;
  localparam int DW    = 32 + CH_W + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   bit_in;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   gnt;
  logic             det_valid;
  logic [CH_W-1:0]  det_ch;
  logic [CNT_W-1:0] hit_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] cyc_cnt = 0;

  // Expected grants tagged with their cycle, expected detections tagged with due cycle.
  logic [GW-1:0] gnt_exp_q[$];
  logic [DW-1:0] det_exp_q[$];
  logic [GW-1:0] ge;
  logic [DW-1:0] de;

  // Reference model: per-channel consumed-bit history and its valid length.
  int         m_ptr;
  int         m_len [NCH];
  logic [3:0] m_hist [NCH];
  int         m_cnt;

  seq_det_arbiter #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .bit_in    (bit_in),
    .clr       (clr),
    .gnt       (gnt),
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .hit_cnt   (hit_cnt)
  );

  // ---------------- clock / cycle counter ----------------
  always #10 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_cnt = 0;
    for (int i = 0; i < NCH; i++) begin
      m_len[i]  = 0;
      m_hist[i] = '0;
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and record what must follow.
  task automatic drive_cycle(input logic [NCH-1:0] r, input logic [NCH-1:0] b,
                             input logic [NCH-1:0] c);
    logic [NCH-1:0] elig;
    logic [NCH-1:0] g;
    int gi;
    int idx;
    @(negedge clk);
    req    = r;
    bit_in = b;
    clr    = c;
    elig = r & ~c;
    g    = '0;
    gi   = -1;
    for (int k = 0; k < NCH; k++) begin
      idx = (m_ptr + k) % NCH;
      if (gi < 0 && elig[idx]) gi = idx;
    end
    if (gi >= 0) g[gi] = 1'b1;
    gnt_exp_q.push_back({cyc_cnt, g});
    for (int i = 0; i < NCH; i++) begin
      if (c[i]) m_len[i] = 0;
    end
    if (gi >= 0) begin
      m_hist[gi] = {m_hist[gi][2:0], b[gi]};
      m_len[gi]  = m_len[gi] + 1;
      if (m_len[gi] >= 4 && m_hist[gi] == 4'b1101) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        det_exp_q.push_back({cyc_cnt + 32'd1, CH_W'(gi), CNT_W'(m_cnt)});
`ifdef SEQ_ARB_NONOVERLAP_EN
        m_len[gi] = 0;
`endif
      end
      m_ptr = (gi + 1) % NCH;
    end
  endtask

  task automatic feed(input int ch, input logic [7:0] pat, input int n);
    logic [NCH-1:0] one;
    one     = '0;
    one[ch] = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      drive_cycle(one, pat[i] ? one : '0, '0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle('0, '0, '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    #2;
    if (gnt_exp_q.size() > 0) begin
      ge = gnt_exp_q[0];
      if (ge[GW-1:NCH] == cyc_cnt) begin
        ge = gnt_exp_q.pop_front();
        check("gnt", int'(gnt), int'(ge[NCH-1:0]));
      end
    end
    while (det_exp_q.size() > 0) begin
      de = det_exp_q[0];
      if (de[DW-1:CH_W+CNT_W] >= cyc_cnt) break;
      de = det_exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL det_missing: got no pulse expected ch %0d cnt %0d",
               de[CH_W+CNT_W-1:CNT_W], de[CNT_W-1:0]);
    end
    if (det_valid === 1'b1) begin
      if (det_exp_q.size() > 0) de = det_exp_q[0];
      if (det_exp_q.size() == 0 || de[DW-1:CH_W+CNT_W] != cyc_cnt) begin
        checks++;
        errors++;
        $display("FAIL det_unexpected: got pulse ch %0d expected none (cycle %0d)",
                 det_ch, cyc_cnt);
      end else begin
        de = det_exp_q.pop_front();
        check("det_ch", int'(det_ch), int'(de[CH_W+CNT_W-1:CNT_W]));
        check("hit_cnt", int'(hit_cnt), int'(de[CNT_W-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] pat4;
    rst_n  = 1'b0;
    req    = '0;
    bit_in = '0;
    clr    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    req = '1;
    #1;
    check("reset_gnt", int'(gnt), 0);
    check("reset_det_valid", int'(det_valid), 0);
    check("reset_det_ch", int'(det_ch), 0);
    check("reset_hit_cnt", int'(hit_cnt), 0);
    req   = '0;
    rst_n = 1'b1;

    // Channel 0 alone: overlapping pattern 1101101.
    feed(0, 8'b0110_1101, 7);
    idle(2);

    // All channels requesting; each gets 1,1,0,1 in round-robin order.
    drive_cycle('1, '0, '1);
    pat4 = 4'b1101;
    for (int p = 3; p >= 0; p--) begin
      for (int c = 0; c < NCH; c++) drive_cycle('1, pat4[p] ? '1 : '0, '0);
    end
    idle(2);

    // Clear of a pending channel withholds its grant and resets its context.
    feed(1, 8'b0000_0110, 3);
    drive_cycle(4'b0010, 4'b0010, 4'b0010);
    feed(1, 8'b0000_0001, 1);
    idle(1);

    // Channel 3 context survives a long request gap while others run.
    feed(3, 8'b0000_0110, 3);
    repeat (10) drive_cycle(NCH'($urandom) & 4'b0101, NCH'($urandom), '0);
    feed(3, 8'b0000_0001, 1);
    idle(2);

    // Asynchronous reset with channel 2 one bit from a hit and a pulse showing.
    feed(2, 8'b0000_0110, 3);
    feed(0, 8'b0000_1101, 4);
    drive_cycle(4'b0100, 4'b0100, '0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_det_valid", int'(det_valid), 0);
    check("async_rst_hit_cnt", int'(hit_cnt), 0);
    check("async_rst_gnt", int'(gnt), 0);
    #1;
    req    = '0;
    bit_in = '0;
    model_reset();
    det_exp_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    feed(2, 8'b0000_0001, 1);
    idle(2);

    // Random traffic with occasional clears.
    repeat (1500) begin
      drive_cycle(NCH'($urandom), NCH'($urandom),
                  ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0);
    end
    idle(3);
    #5;
    check("det_queue_drained", det_exp_q.size(), 0);
    check("gnt_queue_drained", gnt_exp_q.size(), 0);
    check("final_hit_cnt", int'(hit_cnt), m_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
